// File: rtl/bcd_serial_addsub_pkg.sv
// Shared types and constants for the digit-serial BCD add/sub block.
// Digit type, BCD limits, FSM state encoding and a digit validity helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result bus for the digit-serial BCD add/sub block.
// The master presents operands and takes results; the slave is the datapath.
interface bcd_serial_addsub_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   result;
    logic                  ovf;
    logic                  err;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, ovf, err
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, ovf, err
    );

endinterface

// File: rtl/bcd_serial_addsub_digit_cell.sv
// Single BCD digit add/subtract with decimal correction.
// Subtraction uses the nine's complement of b; the caller supplies the +1.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    input  logic       sub,
    output bcd_digit_t digit,
    output logic       cout
);

    bcd_digit_t bd;
    logic [4:0] s;

    // Binary digit sum, then add 6 when it leaves the decimal range
    always_comb begin
        bd    = sub ? (BCD_MAX - b) : b;
        s     = {1'b0, a} + {1'b0, bd} + {4'b0000, cin};
        cout  = (s > {1'b0, BCD_MAX});
        digit = cout ? (s[3:0] + BCD_CORR) : s[3:0];
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor, one digit per clock, LSD first.
// Fixed latency of DIGITS cycles; invalid BCD input zeroes the result.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    bcd_serial_addsub_if.slave  bus
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            sub_q, sub_d;
    logic            carry_q, carry_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic            bad;
    bcd_digit_t      cell_digit;
    logic            cell_cout;

    bcd_digit_cell u_cell (
        .a     (a_q[4*idx_q +: 4]),
        .b     (b_q[4*idx_q +: 4]),
        .cin   (carry_q),
        .sub   (sub_q),
        .digit (cell_digit),
        .cout  (cell_cout)
    );

    // Flag any non-BCD nibble in the presented operands
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | ~is_bcd(bus.a[4*i +: 4]) | ~is_bcd(bus.b[4*i +: 4]);
        end
    end

    // Next-state logic for FSM, digit loop and handshakes
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.sub;
                    err_d   = bad;
                    carry_d = bus.sub;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_d[4*idx_q +: 4] = err_q ? 4'd0 : cell_digit;
                carry_d = cell_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    ovf_d   = err_q ? 1'b0 : (sub_q ? ~cell_cout : cell_cout);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub at DIGITS = 1, 4 and 8.
// Table of hand-computed vectors plus backpressure and reset sequences.
module tb_bcd_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic out_rdy = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_serial_addsub_if #(.DIGITS(1)) i1 ();
    bcd_serial_addsub_if #(.DIGITS(4)) i4 ();
    bcd_serial_addsub_if #(.DIGITS(8)) i8 ();

    assign i1.out_ready = out_rdy;
    assign i4.out_ready = out_rdy;
    assign i8.out_ready = out_rdy;

    bcd_serial_addsub #(.DIGITS(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
    bcd_serial_addsub #(.DIGITS(4)) u4 (.clk(clk), .rst(rst), .bus(i4));
    bcd_serial_addsub #(.DIGITS(8)) u8 (.clk(clk), .rst(rst), .bus(i8));

    typedef struct {
        string       nm;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic        ovf;
        logic        err;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input int w, input logic v, input logic [63:0] a,
                       input logic [63:0] b, input logic s);
        case (w)
            1: begin
                i1.in_valid = v; i1.a = a[3:0]; i1.b = b[3:0]; i1.sub = s;
            end
            8: begin
                i8.in_valid = v; i8.a = a[31:0]; i8.b = b[31:0]; i8.sub = s;
            end
            default: begin
                i4.in_valid = v; i4.a = a[15:0]; i4.b = b[15:0]; i4.sub = s;
            end
        endcase
    endtask

    // {in_ready, out_valid, ovf, err}
    function automatic logic [3:0] f_flags(input int w);
        case (w)
            1: return {i1.in_ready, i1.out_valid, i1.ovf, i1.err};
            8: return {i8.in_ready, i8.out_valid, i8.ovf, i8.err};
            default: return {i4.in_ready, i4.out_valid, i4.ovf, i4.err};
        endcase
    endfunction

    function automatic logic [63:0] f_res(input int w);
        case (w)
            1: return 64'(i1.result);
            8: return 64'(i8.result);
            default: return 64'(i4.result);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int w, input string nm, input logic [63:0] a,
                      input logic [63:0] b, input logic s,
                      input logic [63:0] er, input logic eo, input logic ee);
        logic [3:0] fl;
        int lat;
        lat = 0;
        fl = f_flags(w);
        while (!fl[3] && lat < 40) begin
            step();
            lat++;
            fl = f_flags(w);
        end
        chk({nm, "_in_ready"}, 64'(fl[3]), 64'd1);
        drv(w, 1'b1, a, b, s);
        step();
        drv(w, 1'b0, a, b, s);
        lat = 0;
        fl = f_flags(w);
        while (!fl[2] && lat < 40) begin
            step();
            lat++;
            fl = f_flags(w);
        end
        chk({nm, "_latency"}, 64'(lat), 64'(w));
        chk({nm, "_result"}, f_res(w), er);
        chk({nm, "_ovf"}, 64'(fl[1]), 64'(eo));
        chk({nm, "_err"}, 64'(fl[0]), 64'(ee));
    endtask

    task automatic drain(input int w, input string nm);
        logic [3:0] fl;
        step();
        fl = f_flags(w);
        chk({nm, "_drain_out_valid"}, 64'(fl[2]), 64'd0);
        chk({nm, "_drain_in_ready"}, 64'(fl[3]), 64'd1);
    endtask

    task automatic rst_mid(input int w, input string nm,
                           input logic [63:0] a, input logic [63:0] b);
        logic [3:0] fl;
        drv(w, 1'b1, a, b, 1'b0);
        step();
        drv(w, 1'b0, a, b, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        fl = f_flags(w);
        chk({nm, "_rst_in_ready"}, 64'(fl[3]), 64'd1);
        chk({nm, "_rst_out_valid"}, 64'(fl[2]), 64'd0);
        chk({nm, "_rst_result"}, f_res(w), 64'd0);
        chk({nm, "_rst_ovf"}, 64'(fl[1]), 64'd0);
    endtask

    initial begin
        logic [3:0] fl;

        tv[0] = '{"add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        tv[1] = '{"add_9999_0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[2] = '{"add_0000_0000", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tv[3] = '{"sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b0, 1'b0};
        tv[4] = '{"sub_0001_0002", 16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b1, 1'b0};
        tv[5] = '{"sub_4321_4321", 16'h4321, 16'h4321, 1'b1, 16'h0000, 1'b0, 1'b0};
        tv[6] = '{"err_12A4", 16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
        tv[7] = '{"add_0005_0004", 16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0};

        drv(1, 1'b0, 64'd0, 64'd0, 1'b0);
        drv(4, 1'b0, 64'd0, 64'd0, 1'b0);
        drv(8, 1'b0, 64'd0, 64'd0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        fl = f_flags(4);
        chk("reset_in_ready", 64'(fl[3]), 64'd1);
        chk("reset_out_valid", 64'(fl[2]), 64'd0);
        chk("reset_result", f_res(4), 64'd0);
        chk("reset_ovf", 64'(fl[1]), 64'd0);
        chk("reset_err", 64'(fl[0]), 64'd0);

        for (int i = 0; i < 8; i++) begin
            op(4, tv[i].nm, 64'(tv[i].a), 64'(tv[i].b), tv[i].sub,
               64'(tv[i].res), tv[i].ovf, tv[i].err);
            drain(4, tv[i].nm);
        end

        out_rdy = 1'b0;
        op(4, "bp", 64'h0002, 64'h0003, 1'b0, 64'h0005, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drv(4, 1'b1, 64'h9999, 64'h9999, 1'b0);
            step();
            fl = f_flags(4);
            chk("bp_hold_out_valid", 64'(fl[2]), 64'd1);
            chk("bp_hold_in_ready", 64'(fl[3]), 64'd0);
            chk("bp_hold_result", f_res(4), 64'h0005);
            chk("bp_hold_ovf", 64'(fl[1]), 64'd0);
        end
        drv(4, 1'b0, 64'd0, 64'd0, 1'b0);
        out_rdy = 1'b1;
        step();
        fl = f_flags(4);
        chk("bp_release_out_valid", 64'(fl[2]), 64'd0);
        chk("bp_release_in_ready", 64'(fl[3]), 64'd1);
        chk("bp_idle_result_kept", f_res(4), 64'h0005);
        op(4, "bp_next", 64'h0011, 64'h0022, 1'b0, 64'h0033, 1'b0, 1'b0);
        drain(4, "bp_next");

        op(4, "pre_rst", 64'h1234, 64'h5678, 1'b0, 64'h6912, 1'b0, 1'b0);
        drain(4, "pre_rst");
        rst_mid(4, "d4", 64'h1111, 64'h2222);
        op(4, "d4_after_rst", 64'h0999, 64'h0001, 1'b0, 64'h1000, 1'b0, 1'b0);
        drain(4, "d4_after_rst");

        op(1, "d1_add_7_5", 64'h7, 64'h5, 1'b0, 64'h2, 1'b1, 1'b0);
        drain(1, "d1_add_7_5");
        op(1, "d1_sub_3_4", 64'h3, 64'h4, 1'b1, 64'h9, 1'b1, 1'b0);
        drain(1, "d1_sub_3_4");

        op(8, "d8_pre", 64'h12345678, 64'h87654321, 1'b0,
           64'h99999999, 1'b0, 1'b0);
        drain(8, "d8_pre");
        rst_mid(8, "d8", 64'h11111111, 64'h22222222);
        op(8, "d8_add_carry", 64'h99999999, 64'h00000001, 1'b0,
           64'h00000000, 1'b1, 1'b0);
        drain(8, "d8_add_carry");
        op(8, "d8_sub", 64'h10000000, 64'h00000001, 1'b1,
           64'h09999999, 1'b0, 1'b0);
        drain(8, "d8_sub");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
